// File: rtl/mas_pkg.sv
// Shared types and default constants for the memory access sequencer.
// Default constants are overridable through the module parameters.
package mas_pkg;

   typedef enum logic [1:0] {
      FETCH,
      ISSUE,
      LOAD,
      STORE
   } state_t;

   localparam logic [31:0] DEFAULT_RESET_PC   = 32'd128;
   localparam logic [31:0] DEFAULT_PC_STEP    = 32'd4;
   localparam logic [31:0] DEFAULT_ADDR_LIMIT = 32'd1024;

endpackage

// File: rtl/pc_unit.sv
// Program counter: async reset to RESET_PC, step increment, or load of a redirect target.
// If inc and load are both high, load wins.
module pc_unit
   import mas_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        load,
   input  logic [31:0] target,
   output logic [31:0] pc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= target;
      end else if (inc) begin
         pc <= pc + PC_STEP;
      end
   end

endmodule

// File: rtl/mem_access_sequencer.sv
// Multicycle fetch/load/store sequencer; sole master of the unified Memory port.
// Owns the PC, IR and MDR, and hands results to the core by request/acknowledge.
module mem_access_sequencer
   import mas_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter logic [31:0] PC_STEP    = DEFAULT_PC_STEP,
   parameter logic [31:0] ADDR_LIMIT = DEFAULT_ADDR_LIMIT
) (
   input  logic        Clk,
   input  logic        Reset,
   output logic [31:0] Address,
   output logic [31:0] writeData,
   output logic        writeEnable,
   input  logic [31:0] MemData,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   input  logic        ld_req,
   input  logic        st_req,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        done,
   input  logic        pc_load,
   input  logic [31:0] pc_target,
   output logic [31:0] mem_rdata,
   output logic        mem_ack,
   output logic        fault
);

   state_t      state;
   logic [31:0] ir;
   logic [31:0] mdr;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic        pc_ok;
   logic        addr_ok;
   logic        pc_inc;
   logic        pc_ld;

   assign pc_ok   = (pc < ADDR_LIMIT);
   assign addr_ok = (addr_q < ADDR_LIMIT);

   // A done coinciding with a load/store request is dropped, so it must not redirect.
   assign pc_inc = (state == FETCH) && pc_ok;
   assign pc_ld  = (state == ISSUE) && !ld_req && !st_req && done && pc_load;

   pc_unit #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc (
      .clk    (Clk),
      .rst    (Reset),
      .inc    (pc_inc),
      .load   (pc_ld),
      .target (pc_target),
      .pc     (pc)
   );

   always_comb begin
      Address = pc;
      if (state == LOAD || state == STORE) begin
         Address = addr_q;
      end
   end

   // Decoded from state so an async reset removes the strobe without waiting for a clock.
   assign writeEnable = (state == STORE) && addr_ok;
   assign writeData   = data_q;
   assign instr       = ir;
   assign instr_valid = (state == ISSUE);
   assign mem_rdata   = mdr;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state   <= FETCH;
         ir      <= '0;
         mdr     <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         mem_ack <= 1'b0;
         fault   <= 1'b0;
      end else begin
         mem_ack <= 1'b0;
         fault   <= 1'b0;
         unique case (state)
            FETCH: begin
               if (pc_ok) begin
                  ir <= MemData;
               end else begin
                  ir    <= '0;
                  fault <= 1'b1;
               end
               state <= ISSUE;
            end
            ISSUE: begin
               if (ld_req) begin
                  addr_q <= mem_addr;
                  state  <= LOAD;
               end else if (st_req) begin
                  addr_q <= mem_addr;
                  data_q <= mem_wdata;
                  state  <= STORE;
               end else if (done) begin
                  state <= FETCH;
               end
            end
            LOAD: begin
               if (addr_ok) begin
                  mdr     <= MemData;
                  mem_ack <= 1'b1;
               end else begin
                  mdr   <= '0;
                  fault <= 1'b1;
               end
               state <= ISSUE;
            end
            STORE: begin
               if (addr_ok) begin
                  mem_ack <= 1'b1;
               end else begin
                  fault <= 1'b1;
               end
               state <= ISSUE;
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Multicycle front-end controller that sits directly upstream of the unified instruction/data Memory block and is its only master. It owns the PC, instruction register (IR) and memory data register (MDR), and sequences instruction fetch, load and store cycles onto the single Memory port. It hands fetched instructions and load data to the core datapath through a simple request/acknowledge handshake.

Parameters:
RESET_PC, 128, PC value loaded on reset; this is the first fetch address.
PC_STEP, 4, PC increment per fetch. Memory indexes words by raw Address, with no shift.
ADDR_LIMIT, 1024, number of Memory entries; any address at or above this faults.

Ports:
Clk  in  1  system clock; all state updates on the rising edge.
Reset  in  1  asynchronous, active-high reset.
Address  out  32  Memory address; combinational from state.
writeData  out  32  Memory write data.
writeEnable  out  1  Memory write strobe; Memory writes on the Clk edge while high.
MemData  in  32  Memory combinational read data.
instr  out  32  IR contents.
instr_valid  out  1  high in ISSUE state.
pc  out  32  address of the next fetch (PC+PC_STEP after a fetch).
ld_req  in  1  core requests a load at mem_addr; sampled in ISSUE.
st_req  in  1  core requests a store of mem_wdata at mem_addr; sampled in ISSUE.
mem_addr  in  32  load/store address.
mem_wdata  in  32  store data.
done  in  1  core finished the current instruction; sampled in ISSUE.
pc_load  in  1  qualifies done; redirect the PC to pc_target.
pc_target  in  32  redirect address.
mem_rdata  out  32  MDR contents.
mem_ack  out  1  one-cycle pulse when a load or store completes.
fault  out  1  one-cycle pulse on an out-of-range access.

Behaviour:
- States: FETCH, ISSUE, LOAD, STORE.
- Reset (async): state=FETCH, pc=RESET_PC, IR=0, MDR=0, latched addr/data=0, mem_ack=0, fault=0. Consequently instr_valid=0 and writeEnable=0.
- FETCH:
  - Address=pc, writeEnable=0.
  - On the edge: IR<=MemData, pc<=pc+PC_STEP (32-bit wrap), then go to ISSUE.
  - Fetch latency is 1 cycle.
  - If pc>=ADDR_LIMIT: IR<=0, pc unchanged, fault pulses, go to ISSUE.
- ISSUE:
  - instr_valid=1, Address=pc, writeEnable=0.
  - Priority is ld_req > st_req > done.
  - ld_req: latch mem_addr, go to LOAD.
  - st_req: latch mem_addr and mem_wdata, go to STORE.
  - done: if pc_load, pc<=pc_target; go to FETCH.
  - A done asserted together with ld_req or st_req is ignored; the core must reassert it.
  - With no request, stay in ISSUE; IR holds.
- LOAD:
  - Address=latched addr.
  - On the edge: MDR<=MemData, mem_ack<=1 for the next cycle, return to ISSUE.
  - Out of range: MDR<=0, fault pulses instead of mem_ack.
- STORE:
  - Address=latched addr, writeData=latched data, writeEnable=1 for exactly this one cycle.
  - Return to ISSUE with a mem_ack pulse.
  - Out of range: writeEnable stays 0, fault pulses, no mem_ack.
- writeData=latched data in every state; it only matters while writeEnable=1.
- pc_target is used as given; no alignment check.
- Reset mid-STORE:
  - writeEnable drops immediately (async).
  - Whether the write completes is not guaranteed.
  - No mem_ack is produced.
- mem_ack and fault are never high in the same cycle.
- mem_rdata holds until the next LOAD.

Decomposition:
- Shared package mas_pkg: state enum (FETCH, ISSUE, LOAD, STORE) and default constants RESET_PC, PC_STEP, ADDR_LIMIT.
- One sub-module, pc_unit: PC register with async reset to RESET_PC, increment enable, and load-with-target. Everything else lives in the top FSM.

Test Plan:
- Release Reset -> cycle 0 Address=128. ISSUE shows instr=32'h00221820, pc=132, instr_valid=1.
- In ISSUE, ld_req with mem_addr=2 -> one LOAD cycle with Address=2, then mem_rdata=2 and mem_ack pulses once.
- st_req with mem_addr=6, mem_wdata=32'h55 -> writeEnable high for exactly 1 cycle. A following ld_req at addr 6 returns 32'h55.
- done with pc_load=1, pc_target=144 -> FETCH at Address=144, instr=32'h10600004, pc=148.
- st_req with mem_addr=1024 -> fault pulses, writeEnable never asserts, no mem_ack; a follow-up load of addr 10 still returns 10.
- ld_req and done asserted together -> LOAD taken and pc unchanged. Reset asserted during STORE -> writeEnable=0 immediately; after release, fetch restarts at 128.
